// File: rtl/rtc_bus_master.sv
// rtc_bus_master: sequences single-byte RTC bus writes/reads (CS, A/D, WR, RD, AD) with parameterised phases; reads need RTC_BUS_READ_EN
module rtc_bus_master #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 8,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req,
  input  logic       req_rw,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       fin,
  output logic [7:0] rd_data,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a_d
);
  typedef enum logic [3:0] {IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, DONE, GAP} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, addr_l, data_l, addr_n, data_n;
  logic rw_n, accept, last, a_ph, d_ph, wr_data;
  assign last = cnt == 8'd0;
  // The final GAP edge doubles as an acceptance edge, so a level-held req restarts with no IDLE cycle
  assign accept = req && (state == IDLE || (state == GAP && last));
  assign addr_n = accept ? req_addr : addr_l;
  assign data_n = accept ? req_data : data_l;
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE) ? cnt : cnt - 8'd1;
    if (accept) begin
      state_n = A_SETUP;
      cnt_n = 8'(T_SETUP - 1);
    end else if (state != IDLE && last) begin
      case (state)
        A_SETUP: begin state_n = A_PULSE; cnt_n = 8'(T_PULSE - 1); end
        A_PULSE: begin state_n = A_HOLD;  cnt_n = 8'(T_HOLD - 1);  end
        A_HOLD:  begin state_n = D_SETUP; cnt_n = 8'(T_SETUP - 1); end
        D_SETUP: begin state_n = D_PULSE; cnt_n = 8'(T_PULSE - 1); end
        D_PULSE: begin state_n = D_HOLD;  cnt_n = 8'(T_HOLD - 1);  end
        D_HOLD:  begin state_n = DONE;    cnt_n = 8'd0;            end
        DONE:    begin state_n = GAP;     cnt_n = 8'(T_GAP - 1);   end
        default: begin state_n = IDLE;    cnt_n = 8'd0;            end
      endcase
    end
  end
  assign a_ph = state_n inside {A_SETUP, A_PULSE, A_HOLD};
  assign d_ph = state_n inside {D_SETUP, D_PULSE, D_HOLD};
  assign wr_data = d_ph && !rw_n;
  // Strobes are decoded from the next state and registered so the pins never glitch
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      addr_l <= 8'd0;
      data_l <= 8'd0;
      busy <= 1'b0;
      fin <= 1'b0;
      ad_out <= 8'd0;
      ad_oe <= 1'b0;
      cs_n <= 1'b1;
      wr_n <= 1'b1;
      rd_n <= 1'b1;
      a_d <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr_l <= addr_n;
      data_l <= data_n;
      busy <= state_n != IDLE;
      fin <= state_n == DONE;
      cs_n <= !(a_ph || d_ph);
      wr_n <= !(state_n == A_PULSE || (wr_data && state_n == D_PULSE));
      rd_n <= !(rw_n && state_n == D_PULSE);
      a_d <= !d_ph;
      ad_oe <= a_ph || wr_data;
      ad_out <= a_ph ? addr_n : wr_data ? data_n : 8'd0;
    end
  end
`ifdef RTC_BUS_READ_EN
  logic rw_l;
  assign rw_n = accept ? req_rw : rw_l;
  always_ff @(posedge CLK) begin
    if (reset) begin
      rw_l <= 1'b0;
      rd_data <= 8'd0;
    end else begin
      rw_l <= rw_n;
      if (state == D_PULSE && last && rw_l) rd_data <= ad_in;
    end
  end
`else
  logic unused_rd;
  assign rw_n = 1'b0;
  assign rd_data = 8'd0;
  assign unused_rd = ^{req_rw, ad_in};
`endif
endmodule

// File: tb/tb_rtc_bus_master.sv
// tb_rtc_bus_master: randomized check of rtc_bus_master against a cycle-offset reference model
module tb_rtc_bus_master;
  localparam int S = 2, P = 8, H = 2, G = 3;
  localparam int D0 = S + P + H;
  localparam int L = 2 * D0 + 1 + G;
  logic CLK = 1'b0, reset = 1'b1, req = 1'b0, req_rw = 1'b0;
  logic [7:0] req_addr = 8'd0, req_data = 8'd0, ad_in = 8'd0;
  logic busy, fin, ad_oe, cs_n, wr_n, rd_n, a_d;
  logic [7:0] rd_data, ad_out;
  int vectors = 0, errs = 0;
  bit active = 1'b0, rw_m = 1'b0;
  int o = 0;
  logic [7:0] addr_m = 8'd0, data_m = 8'd0, rd_m = 8'd0;
  rtc_bus_master #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H), .T_GAP(G)) dut (
    .CLK(CLK), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .busy(busy), .fin(fin), .rd_data(rd_data), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a_d(a_d)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic bit in_rng(input int v, input int lo, input int n);
    return v >= lo && v < lo + n;
  endfunction
  initial begin
    bit aph, dph, apl, dpl, wdat;
    repeat (2) @(posedge CLK);
    for (int n = 0; n < 4000; n++) begin
      @(negedge CLK);
      aph = active && o < D0;
      dph = active && in_rng(o, D0, D0);
      apl = active && in_rng(o, S, P);
      dpl = active && in_rng(o, D0 + S, P);
      wdat = dph && !rw_m;
      chk("busy", busy, active);
      chk("fin", fin, active && o == 2 * D0);
      chk("cs_n", cs_n, !(aph || dph));
      chk("a_d", a_d, !dph);
      chk("wr_n", wr_n, !(apl || (dpl && !rw_m)));
      chk("rd_n", rd_n, !(dpl && rw_m));
      chk("ad_oe", ad_oe, aph || wdat);
      chk("ad_out", ad_out, aph ? addr_m : wdat ? data_m : 8'd0);
      chk("rd_data", rd_data, rd_m);
      reset = $urandom_range(0, 149) == 0;
      req = n < 300 ? 1'b1 : $urandom_range(0, 3) != 0;
      req_rw = $urandom_range(0, 1) == 1;
      req_addr = 8'($urandom);
      req_data = 8'($urandom);
      ad_in = 8'($urandom);
      if (reset) begin
        active = 1'b0;
        o = 0;
        rd_m = 8'd0;
      end else begin
`ifdef RTC_BUS_READ_EN
        if (active && rw_m && o == D0 + S + P - 1) rd_m = ad_in;
`endif
        if (req && (!active || o == L - 1)) begin
          active = 1'b1;
          o = 0;
          addr_m = req_addr;
          data_m = req_data;
`ifdef RTC_BUS_READ_EN
          rw_m = req_rw;
`else
          rw_m = 1'b0;
`endif
        end else if (active) begin
          o++;
          if (o == L) active = 1'b0;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
